// File: rtl/ist_trig_fetch_engine.sv
// IST triangle fetch engine: pops intersection-test requests, streams the requested
// triangles from a fixed-latency memory into the per-child trig SRAM, then responds.
module ist_trig_fetch_engine #(
  parameter int RID_WIDTH       = 8,
  parameter int TID_WIDTH       = 4,
  parameter int CID_WIDTH       = 3,
  parameter int NT_WIDTH        = 3,
  parameter int CHILD_IDX_WIDTH = 12,
  parameter int TRIG_WIDTH      = 32,
  parameter int MEM_LAT         = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          ist_mem_req_stream_empty_n,
  output logic                                          ist_mem_req_stream_read,
  input  logic [CHILD_IDX_WIDTH+NT_WIDTH+RID_WIDTH-1:0] ist_mem_req_stream_dout,
  input  logic                                          ist_mem_resp_stream_full_n,
  output logic                                          ist_mem_resp_stream_write,
  output logic [RID_WIDTH-1:0]                          ist_mem_resp_stream_din,
  output logic                                          mem_rd_en,
  output logic [CHILD_IDX_WIDTH-1:0]                    mem_rd_addr,
  input  logic [TRIG_WIDTH-1:0]                         mem_rd_data,
  output logic                                          trig_sram_we,
  output logic [NT_WIDTH+CID_WIDTH-1:0]                 trig_sram_addr,
  output logic [TRIG_WIDTH-1:0]                         trig_sram_wdata,
  output logic                                          busy,
  output logic                                          err_zero
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [NT_WIDTH:0] CNT_ONE = 1;

  state_t                      r_state;
  state_t                      w_nextState;
  logic [RID_WIDTH-1:0]        r_rid;
  logic [NT_WIDTH-1:0]         r_n;
  logic [CHILD_IDX_WIDTH-1:0]  r_base;
  logic [CID_WIDTH-1:0]        r_cid;
  logic [NT_WIDTH:0]           r_issueCnt;
  logic [NT_WIDTH:0]           r_retCnt;
  logic                        r_vldPipe  [MEM_LAT];
  logic [NT_WIDTH-1:0]         r_slotPipe [MEM_LAT];
  logic                        r_errZero;

  logic [RID_WIDTH-1:0]        w_reqRid;
  logic [NT_WIDTH-1:0]         w_reqN;
  logic [CHILD_IDX_WIDTH-1:0]  w_reqIdx;
  logic [NT_WIDTH:0]           w_nExt;
  logic                        w_pop;
  logic                        w_respWr;
  logic                        w_issue;
  logic                        w_ret;
  logic                        w_lastIssue;
  logic                        w_lastRet;

  assign w_reqRid    = ist_mem_req_stream_dout[RID_WIDTH-1:0];
  assign w_reqN      = ist_mem_req_stream_dout[RID_WIDTH +: NT_WIDTH];
  assign w_reqIdx    = ist_mem_req_stream_dout[RID_WIDTH+NT_WIDTH +: CHILD_IDX_WIDTH];
  assign w_nExt      = {1'b0, r_n};

  // Handshakes are masked during reset so nothing is popped, pushed or written then.
  assign w_pop       = (r_state == IDLE) && ist_mem_req_stream_empty_n && !rst;
  assign w_respWr    = (r_state == RESP) && ist_mem_resp_stream_full_n && !rst;
  assign w_issue     = (r_state == ISSUE) && !rst;
  assign w_ret       = r_vldPipe[MEM_LAT-1] && ((r_state == ISSUE) || (r_state == DRAIN)) && !rst;
  assign w_lastIssue = (r_issueCnt + CNT_ONE) == w_nExt;
  assign w_lastRet   = (r_retCnt + CNT_ONE) == w_nExt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_nextState = (w_reqN == '0) ? RESP : ISSUE;
      ISSUE:   if (w_lastIssue) w_nextState = DRAIN;
      DRAIN:   if (w_ret && w_lastRet) w_nextState = RESP;
      RESP:    if (w_respWr) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The valid/slot pipeline mirrors the memory latency; its tail lines up with mem_rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rid      <= '0;
      r_n        <= '0;
      r_base     <= '0;
      r_cid      <= '0;
      r_issueCnt <= '0;
      r_retCnt   <= '0;
      r_errZero  <= 1'b0;
      for (int k = 0; k < MEM_LAT; k++) begin
        r_vldPipe[k]  <= 1'b0;
        r_slotPipe[k] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_rid      <= w_reqRid;
        r_n        <= w_reqN;
        r_base     <= w_reqIdx;
        r_cid      <= w_reqRid[TID_WIDTH +: CID_WIDTH];
        r_issueCnt <= '0;
        r_retCnt   <= '0;
        if (w_reqN == '0) r_errZero <= 1'b1;
      end
      if (w_issue) r_issueCnt <= r_issueCnt + CNT_ONE;
      if (w_ret) r_retCnt <= r_retCnt + CNT_ONE;
      for (int k = MEM_LAT - 1; k > 0; k--) begin
        r_vldPipe[k]  <= r_vldPipe[k-1];
        r_slotPipe[k] <= r_slotPipe[k-1];
      end
      r_vldPipe[0]  <= w_issue;
      r_slotPipe[0] <= r_issueCnt[NT_WIDTH-1:0];
    end
  end

  always_comb begin
    ist_mem_req_stream_read   = w_pop;
    ist_mem_resp_stream_write = w_respWr;
    ist_mem_resp_stream_din   = (r_state == RESP) ? r_rid : '0;
    mem_rd_en                 = w_issue;
    mem_rd_addr               = '0;
    trig_sram_we              = w_ret;
    trig_sram_addr            = '0;
    trig_sram_wdata           = '0;
    busy                      = (r_state != IDLE);
    err_zero                  = r_errZero;
    if (w_issue) mem_rd_addr = r_base + CHILD_IDX_WIDTH'(r_issueCnt);
    if (w_ret) begin
      trig_sram_addr  = {r_slotPipe[MEM_LAT-1], r_cid};
      trig_sram_wdata = mem_rd_data;
    end
  end

endmodule

// File: tb/tb_ist_trig_fetch_engine.sv
// Self-checking bench for ist_trig_fetch_engine: request FIFO, latency memory and
// trig SRAM are modelled here; writes and responses are checked against a scoreboard.
module tb_ist_trig_fetch_engine;

  localparam int MEM_LAT   = 3;
  localparam int LOG_DEPTH = 2048;

  typedef struct {
    logic [11:0] trigIdx;
    logic [2:0]  n;
    logic [7:0]  rid;
    int          expLat;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wrExp_t;

  logic        clk;
  logic        rst;
  logic        ist_mem_req_stream_empty_n;
  logic        ist_mem_req_stream_read;
  logic [22:0] ist_mem_req_stream_dout;
  logic        ist_mem_resp_stream_full_n;
  logic        ist_mem_resp_stream_write;
  logic [7:0]  ist_mem_resp_stream_din;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        trig_sram_we;
  logic [5:0]  trig_sram_addr;
  logic [31:0] trig_sram_wdata;
  logic        busy;
  logic        err_zero;

  int checks = 0;
  int failures = 0;
  int cycleNum = 0;
  int fullLo = 1;
  int fullHi = 0;

  logic [22:0] reqQ[$];
  wrExp_t      wrQ[$];
  logic [7:0]  respQ[$];
  int          popCycles[$];
  int          respCycles[$];
  int          rdCycles[$];
  logic [11:0] rdAddrs[$];
  int          wrCycles[$];

  logic        memVld  [MEM_LAT];
  logic [11:0] memAddr [MEM_LAT];
  logic        respWrLog [LOG_DEPTH];
  logic        reqRdLog  [LOG_DEPTH];
  logic [7:0]  dinLog    [LOG_DEPTH];

  vec_t vecs[5];

  ist_trig_fetch_engine #(.MEM_LAT(MEM_LAT)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .ist_mem_req_stream_empty_n (ist_mem_req_stream_empty_n),
    .ist_mem_req_stream_read    (ist_mem_req_stream_read),
    .ist_mem_req_stream_dout    (ist_mem_req_stream_dout),
    .ist_mem_resp_stream_full_n (ist_mem_resp_stream_full_n),
    .ist_mem_resp_stream_write  (ist_mem_resp_stream_write),
    .ist_mem_resp_stream_din    (ist_mem_resp_stream_din),
    .mem_rd_en                  (mem_rd_en),
    .mem_rd_addr                (mem_rd_addr),
    .mem_rd_data                (mem_rd_data),
    .trig_sram_we               (trig_sram_we),
    .trig_sram_addr             (trig_sram_addr),
    .trig_sram_wdata            (trig_sram_wdata),
    .busy                       (busy),
    .err_zero                   (err_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cycleNum);
    end
  endtask

  task automatic refreshReq();
    ist_mem_req_stream_empty_n = (reqQ.size() != 0);
    ist_mem_req_stream_dout    = (reqQ.size() != 0) ? reqQ[0] : '0;
  endtask

  // Queue a request and push its expected SRAM writes and response onto the scoreboard.
  task automatic applyStimulus(input logic [11:0] idx, input logic [2:0] n, input logic [7:0] rid,
                               input int nWr, input bit expResp);
    wrExp_t e;
    logic [11:0] a;
    reqQ.push_back({idx, n, rid});
    for (int k = 0; k < nWr; k++) begin
      a = idx + 12'(k);
      e.addr = {3'(k), rid[6:4]};
      e.data = 32'hA000 + {20'h0, a};
      wrQ.push_back(e);
    end
    if (expResp) respQ.push_back(rid);
    refreshReq();
  endtask

  // One clock cycle: sample/score DUT outputs at negedge, then update models after posedge.
  task automatic tick();
    logic popNow;
    logic rdEn;
    logic [11:0] rdA;
    wrExp_t e;
    logic [7:0] er;
    @(negedge clk);
    popNow = ist_mem_req_stream_read && ist_mem_req_stream_empty_n;
    rdEn = mem_rd_en;
    rdA = mem_rd_addr;
    if (popNow) popCycles.push_back(cycleNum);
    if (cycleNum < LOG_DEPTH) begin
      respWrLog[cycleNum] = ist_mem_resp_stream_write;
      reqRdLog[cycleNum]  = ist_mem_req_stream_read;
      dinLog[cycleNum]    = ist_mem_resp_stream_din;
    end
    if (rdEn) begin
      rdCycles.push_back(cycleNum);
      rdAddrs.push_back(rdA);
    end
    if (trig_sram_we) begin
      wrCycles.push_back(cycleNum);
      if (wrQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: addr=%0h data=%0h (cycle %0d)", trig_sram_addr, trig_sram_wdata, cycleNum);
      end else begin
        e = wrQ.pop_front();
        checkOutput("sram_addr", trig_sram_addr, e.addr);
        checkOutput("sram_data", trig_sram_wdata, e.data);
      end
    end
    if (ist_mem_resp_stream_write) begin
      respCycles.push_back(cycleNum);
      checkOutput("resp_write_needs_space", ist_mem_resp_stream_full_n, 1);
      if (respQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_resp: rid=%0h (cycle %0d)", ist_mem_resp_stream_din, cycleNum);
      end else begin
        er = respQ.pop_front();
        checkOutput("resp_rid", ist_mem_resp_stream_din, er);
      end
    end
    @(posedge clk);
    #1;
    cycleNum++;
    for (int k = MEM_LAT - 1; k > 0; k--) begin
      memVld[k]  = memVld[k-1];
      memAddr[k] = memAddr[k-1];
    end
    memVld[0]  = rdEn;
    memAddr[0] = rdA;
    mem_rd_data = memVld[MEM_LAT-1] ? (32'hA000 + {20'h0, memAddr[MEM_LAT-1]}) : 32'hDEADBEEF;
    if (popNow && reqQ.size() != 0) void'(reqQ.pop_front());
    refreshReq();
    ist_mem_resp_stream_full_n = !(cycleNum >= fullLo && cycleNum <= fullHi);
  endtask

  task automatic waitResp(input int target, input int budget);
    int spent = 0;
    while (respCycles.size() < target && spent < budget) begin
      tick();
      spent++;
    end
    if (respCycles.size() < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL resp_timeout: got=%0d responses expected=%0d", respCycles.size(), target);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
    checkOutput({tag, "_we"}, trig_sram_we, 0);
    checkOutput({tag, "_resp_write"}, ist_mem_resp_stream_write, 0);
    checkOutput({tag, "_req_read"}, ist_mem_req_stream_read, 0);
    checkOutput({tag, "_din"}, ist_mem_resp_stream_din, 0);
    checkOutput({tag, "_err_zero"}, err_zero, 0);
  endtask

  task automatic runVector(input vec_t v);
    int p0;
    int r0;
    int p;
    logic [11:0] ea;
    rdCycles.delete();
    rdAddrs.delete();
    wrCycles.delete();
    p0 = popCycles.size();
    r0 = respCycles.size();
    applyStimulus(v.trigIdx, v.n, v.rid, int'(v.n), 1'b1);
    tick();
    #1 checkOutput("busy_after_pop", busy, 1);
    waitResp(r0 + 1, 40);
    checkOutput("pop_count", popCycles.size(), p0 + 1);
    if (popCycles.size() > p0 && respCycles.size() > r0) begin
      p = popCycles[p0];
      checkOutput("resp_latency", respCycles[r0] - p, v.expLat);
      checkOutput("rd_count", rdCycles.size(), v.n);
      for (int k = 0; k < rdCycles.size() && k < int'(v.n); k++) begin
        ea = v.trigIdx + 12'(k);
        checkOutput("rd_cycle", rdCycles[k] - p, k + 1);
        checkOutput("rd_addr", rdAddrs[k], ea);
      end
      checkOutput("wr_count", wrCycles.size(), v.n);
      for (int k = 0; k < wrCycles.size() && k < int'(v.n); k++)
        checkOutput("wr_cycle", wrCycles[k] - p, k + 1 + MEM_LAT);
    end
    checkOutput("err_zero", err_zero, v.expErr);
    checkOutput("wr_queue_drained", wrQ.size(), 0);
  endtask

  initial begin
    int c0;
    int r0;
    int p0;
    vec_t v;

    vecs[0] = '{12'h010, 3'd2, 8'h35, 6,  1'b0};
    vecs[1] = '{12'h3C0, 3'd0, 8'h12, 1,  1'b1};
    vecs[2] = '{12'hFFE, 3'd7, 8'h40, 11, 1'b1};
    vecs[3] = '{12'h7A5, 3'd5, 8'hC9, 9,  1'b1};
    vecs[4] = '{12'h001, 3'd1, 8'h0E, 5,  1'b1};

    rst = 1'b1;
    ist_mem_req_stream_empty_n = 1'b0;
    ist_mem_req_stream_dout    = '0;
    ist_mem_resp_stream_full_n = 1'b1;
    mem_rd_data = 32'hDEADBEEF;
    for (int k = 0; k < MEM_LAT; k++) begin
      memVld[k]  = 1'b0;
      memAddr[k] = '0;
    end

    repeat (3) begin
      tick();
      #1 checkIdleOutputs("reset");
    end
    rst = 1'b0;
    tick();
    #1 checkIdleOutputs("post_reset");

    for (int i = 0; i < 5; i++) runVector(vecs[i]);

    // Backpressure: response held for four cycles, queued request must wait behind it.
    r0 = respCycles.size();
    p0 = popCycles.size();
    c0 = cycleNum;
    fullLo = c0 + 6;
    fullHi = c0 + 9;
    applyStimulus(12'h010, 3'd2, 8'h35, 2, 1'b1);
    applyStimulus(12'h020, 3'd1, 8'h22, 1, 1'b1);
    waitResp(r0 + 2, 60);
    fullLo = 1;
    fullHi = 0;
    if (respCycles.size() >= r0 + 2 && popCycles.size() >= p0 + 2) begin
      checkOutput("bp_resp_cycle", respCycles[r0] - c0, 10);
      checkOutput("bp_next_pop", popCycles[p0+1] - c0, 11);
      checkOutput("bp_next_resp", respCycles[r0+1] - c0, 16);
    end
    for (int k = 6; k <= 9; k++) begin
      checkOutput("bp_no_write", respWrLog[c0+k], 0);
      checkOutput("bp_no_pop", reqRdLog[c0+k], 0);
      checkOutput("bp_din_held", dinLog[c0+k], 8'h35);
    end

    // Back-to-back: responses in order, B popped the cycle after A's response.
    r0 = respCycles.size();
    p0 = popCycles.size();
    applyStimulus(12'h100, 3'd1, 8'h01, 1, 1'b1);
    applyStimulus(12'h200, 3'd3, 8'h7F, 3, 1'b1);
    waitResp(r0 + 2, 60);
    if (respCycles.size() >= r0 + 2 && popCycles.size() >= p0 + 2) begin
      checkOutput("b2b_b_pop", popCycles[p0+1] - respCycles[r0], 1);
      checkOutput("b2b_b_latency", respCycles[r0+1] - popCycles[p0+1], 7);
    end
    checkOutput("b2b_err_sticky", err_zero, 1);

    // Reset during DRAIN: only slot 0 is written, no response ever appears.
    r0 = respCycles.size();
    wrCycles.delete();
    applyStimulus(12'h050, 3'd4, 8'h23, 1, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err_cleared", err_zero, 0);
    repeat (6) tick();
    checkOutput("rst_no_resp", respCycles.size(), r0);
    checkOutput("rst_writes", wrCycles.size(), 1);
    checkOutput("rst_wr_queue", wrQ.size(), 0);
    v = '{12'h0A0, 3'd2, 8'h66, 6, 1'b0};
    runVector(v);

    checkOutput("resp_queue_drained", respQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ist_trig_fetch_engine.md
Name: ist_trig_fetch_engine

Overview:
- Synthesizable, parametrised successor to the simulation-only IST triangle-memory model.
- Pops intersection-test requests {trig_idx, num_trigs, rid} from the IST request stream.
- Streams num_trigs consecutive triangles from a fixed-latency backing memory into the per-child trig SRAM, one triangle per cycle.
- Pushes rid onto the IST response stream once the last triangle is written. Sits between the traversal core's IST request/response FIFOs and the trig SRAM write port.

Parameters:
- RID_WIDTH, 8, ray id width.
- TID_WIDTH, 4, thread-id field at rid[TID_WIDTH-1:0].
- CID_WIDTH, 3, child-id field at rid[TID_WIDTH +: CID_WIDTH].
- NT_WIDTH, 3, num_trigs field width; also the slot index width.
- CHILD_IDX_WIDTH, 12, backing-memory triangle index width.
- TRIG_WIDTH, 32, triangle record width.
- MEM_LAT, 3, backing-memory read latency in cycles; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ist_mem_req_stream_empty_n  in  1  request available; dout valid while high.
- ist_mem_req_stream_read  out  1  pop request.
- ist_mem_req_stream_dout  in  CHILD_IDX_WIDTH+NT_WIDTH+RID_WIDTH  {trig_idx, num_trigs, rid}, MSB first.
- ist_mem_resp_stream_full_n  in  1  response FIFO has space.
- ist_mem_resp_stream_write  out  1  push response.
- ist_mem_resp_stream_din  out  RID_WIDTH  completed rid.
- mem_rd_en  out  1  backing-memory read strobe.
- mem_rd_addr  out  CHILD_IDX_WIDTH  read index.
- mem_rd_data  in  TRIG_WIDTH  read data, valid exactly MEM_LAT cycles after mem_rd_en.
- trig_sram_we  out  1  trig SRAM write enable.
- trig_sram_addr  out  NT_WIDTH+CID_WIDTH  write address {slot, cid}.
- trig_sram_wdata  out  TRIG_WIDTH  write data.
- busy  out  1  high in any state other than IDLE.
- err_zero  out  1  sticky: a request with num_trigs==0 was seen.

Behaviour:
- Reset: state=IDLE. All outputs 0. Issue/return counters cleared. The MEM_LAT-deep return-valid shift register is cleared, so any in-flight read data returning after reset is ignored. err_zero cleared.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - ist_mem_req_stream_read = ist_mem_req_stream_empty_n (combinational).
  - On pop, latch rid, num_trigs (n), trig_idx (base), and cid = rid[TID_WIDTH +: CID_WIDTH].
  - n==0: set err_zero, go to RESP (no reads, no writes).
  - Otherwise go to ISSUE with issue count i=0.
- ISSUE:
  - Each cycle: mem_rd_en=1, mem_rd_addr = base+i, truncated to CHILD_IDX_WIDTH (wraps modulo 2^CHILD_IDX_WIDTH). Push {valid=1, slot=i} into the return pipeline; i++.
  - After the n-th issue, go to DRAIN. Never stalls.
- Return path, active in ISSUE and DRAIN:
  - When the pipeline tail is valid: trig_sram_we=1, trig_sram_addr={slot[NT_WIDTH-1:0], cid}, trig_sram_wdata=mem_rd_data, all combinational that cycle. Return count increments.
  - Writes occur in slot order 0..n-1, one per cycle, contiguous.
- DRAIN: when the return count reaches n (the cycle after the last write), go to RESP.
- RESP:
  - ist_mem_resp_stream_write = ist_mem_resp_stream_full_n; din = latched rid.
  - On write, go to IDLE. While full_n=0, hold and keep din stable.
  - No new request is popped until the RESP write completes; responses are strictly in request order.
- Latency: pop at cycle 0. Reads are issued in cycles 1..n. Writes occur in cycles 1+MEM_LAT .. n+MEM_LAT. Response is written at cycle n+MEM_LAT+1 if full_n=1. For n==0, the response is written at cycle 1.
- Throughput: one request in flight. The next pop can occur the cycle after the response is written.
- Max n = 2^NT_WIDTH-1. No separate counter overflow case exists; counters are NT_WIDTH+1 bits wide.
- Reset mid-operation: returns to IDLE next cycle. A partially written request produces no response. The request stays popped and is not replayed.

Test Plan:
- Single request: rid=0x35 (cid=3), n=2, trig_idx=0x010, memory[k]=0xA000+k, MEM_LAT=3. Pop at cycle 0 → rd_addr 0x010 and 0x011 at cycles 1–2. Writes addr {0,3}=0x03 data 0xA010 at cycle 4, addr {1,3}=0x0B data 0xA011 at cycle 5. Response rid 0x35 at cycle 6.
- Backpressure: same request with full_n=0 during cycles 6–9 → resp_write=0 and req_read=0 in those cycles, din held at 0x35. Write at cycle 10, then the next request is popped at cycle 11.
- Zero count: n=0, rid=0x12 → no mem_rd_en, no trig_sram_we. Response 0x12 at cycle 1, err_zero=1 and it stays 1 through later good requests.
- Wrap and max: trig_idx=0xFFE, n=7 → rd_addr sequence FFE, FFF, 000 .. 004. Slots 0..6 written contiguously. Response at cycle 11.
- Back-to-back: requests A (rid 0x01, n=1) and B (rid 0x7F, n=3) queued → responses in order 0x01 then 0x7F. B's writes go to cid 7, slots 0–2.
- Reset mid-op: assert rst during the DRAIN of an n=4 request → no further trig_sram_we despite pending mem_rd_data, no response, busy=0. The next request completes normally.
